// File: rtl/qpu_exu_alu_dpath_arb.sv
// Round-robin arbiter for the shared EXU ALU datapath (ALU / BJP / QIU requesters),
// with one registered valid/ready response slot per requester.
module qpu_exu_alu_dpath_arb #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            alu_i_valid,
    output logic            alu_i_ready,
    input  logic            bjp_i_valid,
    output logic            bjp_i_ready,
    input  logic            qiu_i_valid,
    output logic            qiu_i_ready,
    output logic            dp_alu_req,
    output logic            dp_bjp_req,
    output logic            dp_qiu_req,
    input  logic [XLEN-1:0] dp_alu_res,
    input  logic            dp_cmp_res,
    output logic            alu_o_valid,
    input  logic            alu_o_ready,
    output logic [XLEN-1:0] alu_o_res,
    output logic            bjp_o_valid,
    input  logic            bjp_o_ready,
    output logic            bjp_o_cmp_res,
    output logic            qiu_o_valid,
    input  logic            qiu_o_ready,
    output logic [XLEN-1:0] qiu_o_res
);

    logic [1:0]      r_rr_ptr;
    logic [1:0]      w_ptr;
    logic [1:0]      w_ptr_nxt;
    logic [2:0]      w_vld_in;
    logic [2:0]      w_rdy_out;
    logic [2:0]      w_elig;
    logic [2:0]      w_grant;
    logic [2:0]      r_o_vld;
    logic [XLEN-1:0] r_alu_res;
    logic [XLEN-1:0] r_qiu_res;
    logic            r_bjp_cmp;

    // Bit order everywhere: [0]=ALU, [1]=BJP, [2]=QIU
    assign w_vld_in  = {qiu_i_valid, bjp_i_valid, alu_i_valid};
    assign w_rdy_out = {qiu_o_ready, bjp_o_ready, alu_o_ready};

    // A slot may be refilled in the same cycle its consumer drains it
    assign w_elig = w_vld_in & (~r_o_vld | w_rdy_out) & {3{~flush}};

    assign w_ptr = (r_rr_ptr == 2'd3) ? 2'd0 : r_rr_ptr;

    always_comb begin
        w_grant = 3'b000;
        case (w_ptr)
            2'd1: begin
                if (w_elig[1])      w_grant = 3'b010;
                else if (w_elig[2]) w_grant = 3'b100;
                else if (w_elig[0]) w_grant = 3'b001;
            end
            2'd2: begin
                if (w_elig[2])      w_grant = 3'b100;
                else if (w_elig[0]) w_grant = 3'b001;
                else if (w_elig[1]) w_grant = 3'b010;
            end
            default: begin
                if (w_elig[0])      w_grant = 3'b001;
                else if (w_elig[1]) w_grant = 3'b010;
                else if (w_elig[2]) w_grant = 3'b100;
            end
        endcase
    end

    always_comb begin
        w_ptr_nxt = w_ptr;
        unique case (1'b1)
            w_grant[0]: w_ptr_nxt = 2'd1;
            w_grant[1]: w_ptr_nxt = 2'd2;
            w_grant[2]: w_ptr_nxt = 2'd0;
            default:    w_ptr_nxt = w_ptr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 2'd0;
        end else begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    // Valid: flush beats everything, then a new grant beats a drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_vld <= 3'b000;
        end else if (flush) begin
            r_o_vld <= 3'b000;
        end else begin
            r_o_vld <= w_grant | (r_o_vld & ~w_rdy_out);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_res <= '0;
            r_bjp_cmp <= 1'b0;
            r_qiu_res <= '0;
        end else begin
            if (w_grant[0]) r_alu_res <= dp_alu_res;
            if (w_grant[1]) r_bjp_cmp <= dp_cmp_res;
            if (w_grant[2]) r_qiu_res <= dp_alu_res;
        end
    end

    assign alu_i_ready   = w_grant[0];
    assign bjp_i_ready   = w_grant[1];
    assign qiu_i_ready   = w_grant[2];
    assign dp_alu_req    = w_grant[0];
    assign dp_bjp_req    = w_grant[1];
    assign dp_qiu_req    = w_grant[2];
    assign alu_o_valid   = r_o_vld[0];
    assign bjp_o_valid   = r_o_vld[1];
    assign qiu_o_valid   = r_o_vld[2];
    assign alu_o_res     = r_alu_res;
    assign bjp_o_cmp_res = r_bjp_cmp;
    assign qiu_o_res     = r_qiu_res;

    a_dp_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({dp_alu_req, dp_bjp_req, dp_qiu_req}));
    a_rdy_has_vld: assert property (@(posedge clk) disable iff (!rst_n)
        (w_grant & ~w_vld_in) == 3'b000);
    a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_rr_ptr != 2'd3);

endmodule
